timer_bank: RTL and testbench

//  Parametrised OPL-style timer bank: NUM_TIMERS up-counting interval timers, each with its own preset and tick rate.

---
 rtl/timer_bank.sv | 181 ++++++++++++++++++
 tb/tb_timer_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: OPL-style bank of NUM_TIMERS up-counting interval timers that
// share one free-running base prescaler. Each timer has its own preset and
// tick divider. The bank keeps sticky per-timer overflow flags, a global IRQ
// reset and per-timer masks, and drives a registered active-low IRQ.
// Optional feature macro: TIMER_BANK_ONESHOT_EN adds a oneshot register at
// MASK_ADDR+1. A oneshot timer stops itself on its first natural overflow.

// One timer channel: tick divider plus up-counter with reload on overflow.
module timer_bank_lane #(
   parameter int CNT_WIDTH = 8,
   parameter int DIV       = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 base_tick,
   input  logic                 run,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] preset,
   output logic                 ovf
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DW-1:0]        div_cnt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 tick;

   assign tick = run && base_tick && (div_cnt == DW'(DIV - 1));
   assign ovf  = tick && (&cnt);

   // Divider and counter. A start edge loads the preset; a stopped timer holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         cnt     <= '0;
      end else if (load) begin
         div_cnt <= '0;
         cnt     <= preset;
      end else if (run && base_tick) begin
         if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            cnt     <= (&cnt) ? preset : cnt + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule

module timer_bank #(
   parameter int                       NUM_TIMERS  = 2,
   parameter int                       CNT_WIDTH   = 8,
   parameter int                       DATA_WIDTH  = 8,
   parameter int                       ADDR_WIDTH  = 8,
   parameter int                       BASE_TICK   = 4000,
   parameter logic [NUM_TIMERS*8-1:0]  TICK_DIVS   = {8'd4, 8'd1},
   parameter logic [ADDR_WIDTH-1:0]    PRESET_ADDR = 8'h02,
   parameter logic [ADDR_WIDTH-1:0]    CTRL_ADDR   = 8'h04,
   parameter logic [ADDR_WIDTH-1:0]    MASK_ADDR   = 8'h05
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  reg_wr_valid,
   input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
   input  logic [DATA_WIDTH-1:0] reg_wr_data,
   input  logic [NUM_TIMERS-1:0] force_overflow,
   output logic [NUM_TIMERS-1:0] overflow_pulse,
   output logic [DATA_WIDTH-1:0] status,
   output logic                  irq_n
);
   localparam int PW = $clog2(BASE_TICK);

   logic [PW-1:0]                        base_cnt;
   logic                                 base_tick;
   logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] preset;
   logic [NUM_TIMERS-1:0]                wr_preset;
   logic [NUM_TIMERS-1:0]                start, start_nxt, load;
   logic [NUM_TIMERS-1:0]                mask, flag, nat_ovf;
   logic                                 irq_rst, irq_rst_nxt, irq;
   logic                                 wr_ctrl, wr_mask;

   assign wr_ctrl   = reg_wr_valid && (reg_wr_addr == CTRL_ADDR);
   assign wr_mask   = reg_wr_valid && (reg_wr_addr == MASK_ADDR);
   assign base_tick = (base_cnt == PW'(BASE_TICK - 1));

   // Free-running base prescaler, 0..BASE_TICK-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) base_cnt <= '0;
      else          base_cnt <= base_tick ? '0 : base_cnt + 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_TIMERS; g++) begin : g_lane
         assign wr_preset[g] = reg_wr_valid &&
                               (reg_wr_addr == ADDR_WIDTH'(PRESET_ADDR + g));

         timer_bank_lane #(
            .CNT_WIDTH (CNT_WIDTH),
            .DIV       (int'(TICK_DIVS[g*8 +: 8]))
         ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .base_tick (base_tick),
            .run       (start[g]),
            .load      (load[g]),
            .preset    (preset[g]),
            .ovf       (nat_ovf[g])
         );

         // Preset register; a running timer only sees it on its next reload
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)          preset[g] <= '0;
            else if (wr_preset[g]) preset[g] <= reg_wr_data[CNT_WIDTH-1:0];
         end
      end
   endgenerate

`ifdef TIMER_BANK_ONESHOT_EN
   localparam logic [ADDR_WIDTH-1:0] ONESHOT_ADDR = MASK_ADDR + 1'b1;
   logic [NUM_TIMERS-1:0] oneshot;

   // Oneshot enable register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         oneshot <= '0;
      else if (reg_wr_valid && (reg_wr_addr == ONESHOT_ADDR))
         oneshot <= reg_wr_data[NUM_TIMERS-1:0];
   end
`endif

   // Next start bits: oneshot overflow stops a timer, but a control write wins
   always_comb begin
      start_nxt = start;
`ifdef TIMER_BANK_ONESHOT_EN
      start_nxt = start_nxt & ~(oneshot & nat_ovf);
`endif
      if (wr_ctrl) start_nxt = reg_wr_data[NUM_TIMERS-1:0];
   end

   // Only a 0->1 start transition reloads the counter and clears the divider
   assign load = start_nxt & ~start;

   // The incoming irq_rst value is used so a write landing on the same edge
   // as a flag set still suppresses it.
   assign irq_rst_nxt = wr_mask ? reg_wr_data[DATA_WIDTH-1] : irq_rst;

   // Control, mask and irq_rst registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start   <= '0;
         mask    <= '0;
         irq_rst <= 1'b0;
      end else begin
         start   <= start_nxt;
         irq_rst <= irq_rst_nxt;
         if (wr_mask) mask <= reg_wr_data[NUM_TIMERS-1:0];
      end
   end

   // Overflow strobe, sticky flags and the registered interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_pulse <= '0;
         flag           <= '0;
         irq_n          <= 1'b1;
      end else begin
         overflow_pulse <= nat_ovf | force_overflow;
         flag           <= irq_rst_nxt ? '0 : (flag | (overflow_pulse & ~mask));
         irq_n          <= !irq;
      end
   end

   assign irq = |flag;

   // Status byte: irq on top, flag[i] below it in timer order
   always_comb begin
      status = '0;
      status[DATA_WIDTH-1] = irq;
      for (int i = 0; i < NUM_TIMERS; i++) status[DATA_WIDTH-2-i] = flag[i];
   end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus randomized register traffic,
// all compared each cycle against a tick/remaining-count model of the bank.
module tb_timer_bank;
   localparam int          NT   = 2;
   localparam int          BT   = 5;
   localparam logic [15:0] DIVS = {8'd4, 8'd1};

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          reg_wr_valid = 1'b0;
   logic [7:0]    reg_wr_addr = '0;
   logic [7:0]    reg_wr_data = '0;
   logic [NT-1:0] force_overflow = '0;
   logic [NT-1:0] overflow_pulse;
   logic [7:0]    status;
   logic          irq_n;

   always #5 clk = ~clk;

   timer_bank #(
      .NUM_TIMERS (NT), .CNT_WIDTH (8), .DATA_WIDTH (8), .ADDR_WIDTH (8),
      .BASE_TICK  (BT), .TICK_DIVS (DIVS)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .reg_wr_valid   (reg_wr_valid),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .force_overflow (force_overflow),
      .overflow_pulse (overflow_pulse),
      .status         (status),
      .irq_n          (irq_n)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: per-timer base-tick count and ticks left to overflow
   int            cyc;
   int            btc[NT];
   int            rem[NT];
   int            divs[NT] = '{1, 4};
   logic [7:0]    m_preset[NT];
   logic [NT-1:0] m_start, m_mask, m_oneshot, m_flag, m_pulse;
   logic          m_irq_rst, m_irq_n;

   function automatic logic [7:0] exp_status();
      logic [7:0] s;
      s = '0;
      s[7] = |m_flag;
      for (int i = 0; i < NT; i++) s[6-i] = m_flag[i];
      return s;
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < NT; i++) begin
         btc[i] = 0; rem[i] = 0; m_preset[i] = '0;
      end
      m_start = '0; m_mask = '0; m_oneshot = '0; m_flag = '0; m_pulse = '0;
      m_irq_rst = 1'b0; m_irq_n = 1'b1;
   endtask

   // Advance the model across one clock edge with the given inputs applied
   task automatic model_step(input logic v, input logic [7:0] a, input logic [7:0] d,
                             input logic [NT-1:0] f);
      logic [NT-1:0] nat, nxt_start;
      logic          nxt_rst;
      bit            bt;
      nat = '0;
      bt  = (cyc % BT) == BT - 1;
      for (int i = 0; i < NT; i++) begin
         if (m_start[i] && bt) begin
            btc[i]++;
            if (btc[i] % divs[i] == 0) begin
               rem[i]--;
               if (rem[i] == 0) begin
                  nat[i] = 1'b1;
                  rem[i] = 256 - int'(m_preset[i]);
               end
            end
         end
      end
      nxt_rst = (v && a == 8'h05) ? d[7] : m_irq_rst;
      m_irq_n = !(|m_flag);
      m_flag  = nxt_rst ? '0 : (m_flag | (m_pulse & ~m_mask));
      m_pulse = nat | f;
      nxt_start = m_start;
`ifdef TIMER_BANK_ONESHOT_EN
      nxt_start = nxt_start & ~(nat & m_oneshot);
`endif
      if (v && a == 8'h04) nxt_start = d[NT-1:0];
      for (int i = 0; i < NT; i++)
         if (nxt_start[i] && !m_start[i]) begin
            btc[i] = 0;
            rem[i] = 256 - int'(m_preset[i]);
         end
      m_start = nxt_start;
      for (int i = 0; i < NT; i++)
         if (v && a == 8'(2 + i)) m_preset[i] = d;
      if (v && a == 8'h05) begin
         m_mask    = d[NT-1:0];
         m_irq_rst = d[7];
      end
`ifdef TIMER_BANK_ONESHOT_EN
      if (v && a == 8'h06) m_oneshot = d[NT-1:0];
`endif
      cyc++;
   endtask

   // Called at a negedge: compare outputs, apply inputs, advance one cycle
   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] d,
                       input logic [NT-1:0] f);
      chk("pulse",  32'(overflow_pulse), 32'(m_pulse));
      chk("status", 32'(status),         32'(exp_status()));
      chk("irq_n",  32'(irq_n),          32'(m_irq_n));
      reg_wr_valid = v; reg_wr_addr = a; reg_wr_data = d; force_overflow = f;
      model_step(v, a, d, f);
      @(posedge clk);
      @(negedge clk);
      reg_wr_valid = 1'b0; force_overflow = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b1, a, d, '0);
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 8'h00, '0);
   endtask

   // Step idle cycles until overflow_pulse[idx] is visible; n = -1 on timeout
   task automatic wait_pulse(input int idx, input int budget, output int n);
      n = -1;
      for (int k = 0; k < budget; k++) begin
         if (overflow_pulse[idx]) begin
            n = k;
            return;
         end
         idle();
      end
   endtask

   initial begin
      int n, cnt;
      model_reset();
      #12;
      chk("rst_status", 32'(status), 32'h0);
      chk("rst_irq_n", 32'(irq_n), 32'h1);
      chk("rst_pulse", 32'(overflow_pulse), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Timer0 preset FE: overflow on the second tick, flag next, irq after
      wr(8'h02, 8'hFE);
      wr(8'h04, 8'h01);
      wait_pulse(0, 3 * BT, n);
      chk("t1_seen", 32'(n >= BT - 1), 32'h1);
      idle();
      chk("t1_status", 32'(status), 32'hC0);
      chk("t1_irq_hold", 32'(irq_n), 32'h1);
      idle();
      chk("t1_irq_low", 32'(irq_n), 32'h0);

      // Masked overflow sets no flag; unmasked one does
      wr(8'h05, 8'h80);
      wr(8'h05, 8'h01);
      wait_pulse(0, 3 * BT, n);
      chk("t3_seen", 32'(n >= 0), 32'h1);
      idle(); idle();
      chk("t3_masked_status", 32'(status), 32'h00);
      chk("t3_masked_irq", 32'(irq_n), 32'h1);
      wr(8'h05, 8'h00);
      wait_pulse(0, 3 * BT, n);
      idle();
      chk("t3_unmasked", 32'(status), 32'hC0);

      // irq_rst landing with the overflow wins; releasing it re-arms flags
      wr(8'h05, 8'h80);
      wr(8'h05, 8'h00);
      wait_pulse(0, 3 * BT, n);
      chk("t4_seen", 32'(n >= 0), 32'h1);
      wr(8'h05, 8'h80);
      chk("t4_suppressed", 32'(status), 32'h00);
      wr(8'h05, 8'h00);
      wait_pulse(0, 3 * BT, n);
      idle();
      chk("t4_rearmed", 32'(status), 32'hC0);

      // Timer1 preset FF divides by 4: overflow every 4 base ticks
      wr(8'h04, 8'h00);
      wr(8'h03, 8'hFF);
      wr(8'h05, 8'h80);
      wr(8'h05, 8'h00);
      wr(8'h04, 8'h02);
      wait_pulse(1, 5 * BT, n);
      chk("t2_seen", 32'(n >= 0), 32'h1);
      idle();
      chk("t2_status", 32'(status), 32'hA0);
      wait_pulse(1, 5 * BT, n);
      chk("t2_period", 32'(n + 1), 32'(4 * BT));

      // Forced overflow on a stopped timer
      wr(8'h04, 8'h00);
      wr(8'h05, 8'h80);
      wr(8'h05, 8'h00);
      step(1'b0, 8'h00, 8'h00, 2'b01);
      chk("t5_pulse", 32'(overflow_pulse), 32'h1);
      idle();
      chk("t5_status", 32'(status), 32'hC0);
      idle();
      chk("t5_irq", 32'(irq_n), 32'h0);

      // Asynchronous reset mid-cycle
      #2 reset_n = 1'b0;
      #1;
      chk("arst_irq_n", 32'(irq_n), 32'h1);
      chk("arst_status", 32'(status), 32'h0);
      chk("arst_pulse", 32'(overflow_pulse), 32'h0);
      @(posedge clk);
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;

      // Randomized register traffic and forced overflows
      for (int k = 0; k < 3000; k++) begin
         logic          v;
         logic [7:0]    a, d;
         logic [NT-1:0] f;
         v = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 7))
            0, 1:    a = 8'h02;
            2:       a = 8'h03;
            3, 4:    a = 8'h04;
            5:       a = 8'h05;
            6:       a = 8'h06;
            default: a = 8'($urandom);
         endcase
         d = 8'($urandom);
         if (a == 8'h02 || a == 8'h03) d = d | 8'hF0;
         if (a == 8'h05 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
         f = ($urandom_range(0, 31) == 0) ? NT'($urandom) : '0;
         step(v, a, d, f);
      end

`ifdef TIMER_BANK_ONESHOT_EN
      // Oneshot: exactly one overflow, then the timer stays stopped
      wr(8'h04, 8'h00);
      wr(8'h05, 8'h80);
      wr(8'h05, 8'h00);
      wr(8'h06, 8'h01);
      wr(8'h02, 8'hFF);
      wr(8'h04, 8'h01);
      cnt = 0;
      for (int k = 0; k < 10 * BT; k++) begin
         if (overflow_pulse[0]) cnt++;
         idle();
      end
      chk("oneshot_count", 32'(cnt), 32'h1);
`endif

      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
